// File: rtl/issue_hazard_scoreboard.sv
// Issue-stage hazard scoreboard: per-register countdowns of in-flight long-latency writes,
// stalling IF/ID until every source operand can be forwarded.
module issue_hazard_scoreboard #(
   parameter int LOAD_LAT = 1,
   parameter int MUL_LAT  = 3,
   parameter int CNT_W    = 2,
   parameter int ZERO_REG = 31
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        IDValid,
   input  logic        Flush,
   input  logic [4:0]  IFID_rn,
   input  logic [4:0]  IFID_rm,
   input  logic [4:0]  IFID_rd,
   input  logic        UsesRn,
   input  logic        UsesRm,
   input  logic        RegWrite,
   input  logic        MemRead,
   input  logic        MulOp,
   output logic        Stall,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        BubbleSel,
   output logic [31:0] Busy,
   output logic [15:0] StallCount
);

   localparam logic [4:0] ZR = 5'(ZERO_REG);

   logic [CNT_W-1:0] cnt [32];
   logic [CNT_W-1:0] new_lat;
   logic             haz_rn;
   logic             haz_rm;
   logic             haz_waw;
   logic             issue;
   logic             issue_wr;

   always_comb begin
      new_lat = '0;
      if (MemRead)
         new_lat = CNT_W'(LOAD_LAT);
      else if (MulOp)
         new_lat = CNT_W'(MUL_LAT);
   end

   assign haz_rn  = UsesRn && (IFID_rn != ZR) && (cnt[IFID_rn] != '0);
   assign haz_rm  = UsesRm && (IFID_rm != ZR) && (cnt[IFID_rm] != '0);
   // A later writer may not finish before an older long-latency write to the same rd.
   assign haz_waw = RegWrite && (IFID_rd != ZR) && (cnt[IFID_rd] > new_lat);

   assign Stall     = IDValid && !Flush && (haz_rn || haz_rm || haz_waw);
   assign PCWrite   = !Stall;
   assign IFIDWrite = !Stall;
   assign BubbleSel = Stall;

   assign issue    = IDValid && !Flush && !Stall;
   assign issue_wr = issue && RegWrite && (IFID_rd != ZR) && (new_lat != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < 32; r++)
            cnt[r] <= '0;
      end else begin
         for (int r = 0; r < 32; r++) begin
            if (issue_wr && (IFID_rd == 5'(r)))
               cnt[r] <= new_lat;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      Busy = '0;
      for (int r = 0; r < 32; r++)
         Busy[r] = (cnt[r] != '0) && (r != ZERO_REG);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         StallCount <= '0;
      else if (Stall && (StallCount != 16'hFFFF))
         StallCount <= StallCount + 16'd1;
   end

endmodule

// File: tb/tb_issue_hazard_scoreboard.sv
// Bench for issue_hazard_scoreboard: directed hazard scenarios plus random instruction
// streams, scored against a ready-time model of in-flight register writes.
module tb_issue_hazard_scoreboard;

   localparam int LOAD_LAT = 1;
   localparam int MUL_LAT  = 3;
   localparam int ZERO_REG = 31;

   logic        clk;
   logic        reset_n;
   logic        IDValid, Flush;
   logic [4:0]  IFID_rn, IFID_rm, IFID_rd;
   logic        UsesRn, UsesRm, RegWrite, MemRead, MulOp;
   logic        Stall, PCWrite, IFIDWrite, BubbleSel;
   logic [31:0] Busy;
   logic [15:0] StallCount;

   issue_hazard_scoreboard #(
      .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .CNT_W(2), .ZERO_REG(ZERO_REG)
   ) dut (
      .clk(clk), .reset_n(reset_n), .IDValid(IDValid), .Flush(Flush),
      .IFID_rn(IFID_rn), .IFID_rm(IFID_rm), .IFID_rd(IFID_rd),
      .UsesRn(UsesRn), .UsesRm(UsesRm), .RegWrite(RegWrite),
      .MemRead(MemRead), .MulOp(MulOp),
      .Stall(Stall), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .BubbleSel(BubbleSel),
      .Busy(Busy), .StallCount(StallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        stall;
      logic [31:0] busy;
      logic [15:0] sc;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Model: absolute cycle at which each register's pending result becomes forwardable.
   int   cyc;
   int   ready [32];
   int   sc_model;
   logic last_stall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int remaining(input int r);
      return (ready[r] > cyc) ? ready[r] - cyc : 0;
   endfunction

   task automatic model_reset();
      cyc = 0;
      for (int r = 0; r < 32; r++) ready[r] = 0;
      sc_model = 0;
   endtask

   // Called at posedge+1; drives one cycle of ID-stage inputs and leaves at the next posedge+1.
   task automatic step(input bit v, input bit f, input int rn, input int rm, input int rd,
                       input bit urn, input bit urm, input bit rw, input bit mr, input bit mo);
      int   lat;
      bit   stl, iss;
      exp_t e;
      IDValid = v; Flush = f;
      IFID_rn = 5'(rn); IFID_rm = 5'(rm); IFID_rd = 5'(rd);
      UsesRn = urn; UsesRm = urm; RegWrite = rw; MemRead = mr; MulOp = mo;
      lat = mr ? LOAD_LAT : (mo ? MUL_LAT : 0);
      stl = v && !f && ((urn && rn != ZERO_REG && remaining(rn) > 0) ||
                        (urm && rm != ZERO_REG && remaining(rm) > 0) ||
                        (rw && rd != ZERO_REG && remaining(rd) > lat));
      iss = v && !f && !stl;
      e.stall = stl;
      for (int r = 0; r < 32; r++) e.busy[r] = (r != ZERO_REG) && (remaining(r) > 0);
      e.sc = 16'(sc_model);
      q.push_back(e);
      #3;
      last_stall = Stall;
      @(posedge clk);
      if (iss && rw && rd != ZERO_REG && lat != 0) ready[rd] = cyc + 1 + lat;
      if (stl && sc_model < 65535) sc_model++;
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Presents the same instruction until it issues; returns DUT stall cycles observed.
   task automatic issue_until(input int rn, input int rm, input int rd, input bit urn,
                              input bit urm, input bit rw, input bit mr, input bit mo,
                              output int stalls);
      bit done = 0;
      stalls = 0;
      for (int k = 0; k < 10 && !done; k++) begin
         step(1, 0, rn, rm, rd, urn, urm, rw, mr, mo);
         if (last_stall) stalls++;
         else done = 1;
      end
      if (!done) chk("issue_timeout", 32'(stalls), 32'hFFFF_FFFF);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall",      32'(Stall),      32'(e.stall));
            chk("pcwrite",    32'(PCWrite),    32'(!e.stall));
            chk("ifidwrite",  32'(IFIDWrite),  32'(!e.stall));
            chk("bubblesel",  32'(BubbleSel),  32'(e.stall));
            chk("busy",       Busy,            e.busy);
            chk("stallcount", 32'(StallCount), 32'(e.sc));
         end
      end
   end

   initial begin : driver
      int st;
      int kind, rd, rn, rm;
      bit v, f;
      reset_n = 0; IDValid = 0; Flush = 0;
      IFID_rn = 0; IFID_rm = 0; IFID_rd = 0;
      UsesRn = 0; UsesRm = 0; RegWrite = 0; MemRead = 0; MulOp = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      chk("reset_busy", Busy, 32'h0);
      chk("reset_stall", 32'(Stall), 32'h0);
      chk("reset_sc", 32'(StallCount), 32'h0);
      idle(2);

      // load-use
      step(1, 0, 0, 0, 1, 0, 0, 1, 1, 0);
      issue_until(1, 0, 4, 1, 0, 1, 0, 0, st);
      chk("loaduse_stalls", 32'(st), 32'(LOAD_LAT));
      chk("loaduse_sc", 32'(StallCount), 32'd1);
      idle(2);

      // multiply then dependent on rm
      step(1, 0, 0, 0, 2, 0, 0, 1, 0, 1);
      issue_until(0, 2, 6, 0, 1, 1, 0, 0, st);
      chk("mul_stalls", 32'(st), 32'(MUL_LAT));
      idle(3);

      // zero register is never tracked
      step(1, 0, 0, 0, 31, 0, 0, 1, 1, 0);
      chk("xzr_busy", Busy, 32'h0);
      issue_until(31, 31, 7, 1, 1, 1, 0, 0, st);
      chk("xzr_stalls", 32'(st), 32'd0);
      idle(2);

      // flush beats a hazard
      step(1, 0, 0, 0, 1, 0, 0, 1, 1, 0);
      step(1, 1, 1, 0, 8, 1, 0, 1, 0, 1);
      chk("flush_stall", 32'(last_stall), 32'd0);
      chk("flush_busy", Busy, 32'h0);
      idle(2);

      // WAW: load behind multiply to the same rd
      step(1, 0, 0, 0, 5, 0, 0, 1, 0, 1);
      issue_until(0, 0, 5, 0, 0, 1, 1, 0, st);
      chk("waw_stalls", 32'(st), 32'd2);
      chk("waw_busy5", 32'(Busy[5]), 32'd1);
      idle(2);

      // asynchronous reset mid-countdown
      step(1, 0, 0, 0, 3, 0, 0, 1, 0, 1);
      step(1, 0, 3, 0, 9, 1, 0, 1, 0, 0);
      IDValid = 1; UsesRn = 1; IFID_rn = 5'd3; RegWrite = 0; MemRead = 0; MulOp = 0;
      #2;
      chk("prereset_stall", 32'(Stall), 32'd1);
      reset_n = 0;
      #1;
      chk("midreset_busy", Busy, 32'h0);
      chk("midreset_stall", 32'(Stall), 32'h0);
      chk("midreset_sc", 32'(StallCount), 32'h0);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1;
      idle(1);

      // random instruction stream
      for (int i = 0; i < 2000; i++) begin
         v    = ($urandom_range(0, 9) != 0);
         f    = ($urandom_range(0, 7) == 0);
         kind = $urandom_range(0, 3);
         rd   = ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 5);
         rn   = ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 5);
         rm   = ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 5);
         step(v, f, rn, rm, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              kind != 3, kind == 0, kind == 1);
      end
      idle(2);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
